// File: rtl/mimasuo_logic.sv
// Two-button sequential combination lock: press-edge detection, digit matching,
// fail counting with timed lockout, registered UNLOCK output.
module mimasuo_logic #(
    parameter int unsigned           CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0]   CODE           = 5'b01001,
    parameter int unsigned           MAX_FAIL       = 3,
    parameter int unsigned           LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button0,
    input  logic button1,
    output logic UNLOCK
);

    localparam int unsigned PW = $clog2(CODE_LEN + 1);
    localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prog_q, prog_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          b0_q, b1_q;

    logic          p0, p1, press, valid, digit, exp_bit, first_bit;
    logic [IW-1:0] idx;

    assign p0        = button0 & ~b0_q;
    assign p1        = button1 & ~b1_q;
    assign press     = p0 | p1;
    assign valid     = p0 ^ p1;
    assign digit     = p1;
    assign first_bit = CODE[CODE_LEN-1];
    assign idx       = IW'(CODE_LEN - 1) - IW'(prog_q);
    assign exp_bit   = CODE[idx];

    // Edge registers load current levels even in reset so a held button never yields a press
    always_ff @(posedge clk) begin
        b0_q <= button0;
        b1_q <= button1;
        if (rst_n) begin
            state_q <= IDLE;
            prog_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            UNLOCK  <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            UNLOCK  <= (state_d == UNLOCKED);
        end
    end

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (press && valid && (digit == first_bit)) begin
                    if (CODE_LEN == 1) begin
                        state_d = UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        state_d = ENTRY;
                        prog_d  = PW'(1);
                    end
                end
            end
            ENTRY: begin
                if (press) begin
                    if (valid && (digit == exp_bit)) begin
                        if (prog_q == PW'(CODE_LEN - 1)) begin
                            state_d = UNLOCKED;
                            prog_d  = '0;
                            fail_d  = '0;
                        end else begin
                            prog_d = prog_q + PW'(1);
                        end
                    end else if (fail_q == FW'(MAX_FAIL - 1)) begin
                        state_d = LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYCLES);
                        prog_d  = '0;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_q + FW'(1);
                        // A wrong digit may itself be the start of a new attempt
                        if (valid && (digit == first_bit)) begin
                            prog_d = PW'(1);
                        end else begin
                            prog_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (press) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q <= TW'(1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mimasuo_logic.sv
// Directed self-checking bench for the two-button combination lock.
module tb_mimasuo_logic;

    logic clk = 1'b0;
    logic rst_n;
    logic button0;
    logic button1;
    logic UNLOCK;

    int errors = 0;
    int checks = 0;

    mimasuo_logic dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .button0 (button0),
        .button1 (button1),
        .UNLOCK  (UNLOCK)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive levels before an edge, return 1 time unit after it
    task automatic step(input logic b0, input logic b1);
        @(negedge clk);
        button0 = b0;
        button1 = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic d);
        step(~d, d);
        step(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        button0 = 1'b0;
        button1 = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        idle(1);
    endtask

    task automatic enter_code();
        press(1'b0); press(1'b1); press(1'b0); press(1'b0); press(1'b1);
    endtask

    initial begin
        rst_n   = 1'b1;
        button0 = 1'b1;
        button1 = 1'b0;

        // Reset with button0 held: no press after reset releases
        @(posedge clk); #1;
        check("reset_unlock", UNLOCK, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        press(1'b1); press(1'b0); press(1'b0); press(1'b1);
        check("held_through_reset", UNLOCK, 1'b0);

        // Correct code, last press is button0 falling as button1 rises
        do_reset();
        press(1'b0); press(1'b1); press(1'b0);
        step(1'b1, 1'b0);
        check("before_final", UNLOCK, 1'b0);
        step(1'b0, 1'b1);
        check("unlock_edge", UNLOCK, 1'b1);
        step(1'b0, 1'b1);
        idle(5);
        check("unlock_held", UNLOCK, 1'b1);

        // Relock; press is consumed so 1,0,0,1 alone must not reopen
        step(1'b1, 1'b0);
        check("relock", UNLOCK, 1'b0);
        step(1'b0, 1'b0);
        press(1'b1); press(1'b0); press(1'b0); press(1'b1);
        check("relock_partial", UNLOCK, 1'b0);

        // Reset while unlocked aborts immediately
        do_reset();
        enter_code();
        check("unlock_again", UNLOCK, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_while_unlocked", UNLOCK, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;

        // Overlap restart: 0,1,0,1,0,1,0,0,1
        idle(1);
        press(1'b0); press(1'b1); press(1'b0); press(1'b1);
        press(1'b0); press(1'b1); press(1'b0); press(1'b0);
        check("overlap_before_final", UNLOCK, 1'b0);
        step(1'b0, 1'b1);
        check("overlap_unlock", UNLOCK, 1'b1);
        step(1'b0, 1'b0);
        // fail_cnt cleared: two more wrong digits must not reach lockout
        press(1'b0);
        check("relock2", UNLOCK, 1'b0);
        press(1'b0); press(1'b0); press(1'b0);
        press(1'b1); press(1'b0); press(1'b0); press(1'b1);
        check("fail_cnt_cleared", UNLOCK, 1'b1);

        // Lockout: 0,0 / 0,0 / 0,0 then code during lockout is ignored
        do_reset();
        press(1'b0); press(1'b0); press(1'b0); press(1'b0);
        press(1'b0); press(1'b0);
        enter_code();
        check("lockout_ignores_code", UNLOCK, 1'b0);
        idle(6);
        enter_code();
        check("after_lockout_unlock", UNLOCK, 1'b1);

        // Held button0 for 10 cycles is a single press
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        press(1'b1); press(1'b0); press(1'b0);
        check("held_before_final", UNLOCK, 1'b0);
        press(1'b1);
        check("held_one_press", UNLOCK, 1'b1);

        // Simultaneous rise in ENTRY is a wrong digit that resets progress
        do_reset();
        press(1'b0); press(1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        press(1'b0); press(1'b0); press(1'b1);
        check("simultaneous_wrong", UNLOCK, 1'b0);
        do_reset();
        enter_code();
        check("code_after_simul", UNLOCK, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
